// File: rtl/d_ff_pipe_if.sv
// Bus interface for the d_ff_pipe delay line: control, input data and the
// registered outputs. clk and reset stay outside as plain module ports.
interface d_ff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             preset;
  logic             flush;
  logic             en;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [CW-1:0]    fill_count;

  // Driver side: issues control and data, observes the pipeline outputs
  modport master (
    output preset, flush, en, d, d_valid,
    input  q, q_valid, fill_count
  );

  // Pipeline side: consumes control and data, produces registered outputs
  modport slave (
    input  preset, flush, en, d, d_valid,
    output q, q_valid, fill_count
  );
endinterface

// File: rtl/d_ff_pipe.sv
// d_ff_pipe: WIDTH-bit, DEPTH-stage stallable register pipeline with per-stage
// valid bits, synchronous preset/flush and a registered occupancy counter.
// Edge priority while out of reset: preset > flush > en > hold.
module d_ff_pipe #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic          clk,
  input  logic          reset,
  d_ff_pipe_if.slave    bus
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] FILL_ONE = CW'(1);

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [CW-1:0]    fill_q;
  logic [CW-1:0]    fill_d;

  // Next-state selection for stage data, stage valids and the occupancy count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      s_d[i] = s_q[i];
    end
    v_d    = v_q;
    fill_d = fill_q;

    if (bus.preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_d[i] = PRESET_VAL;
      end
      v_d    = {DEPTH{1'b1}};
      fill_d = FILL_MAX;
    end else if (bus.flush) begin
      // Data is deliberately retained; only the qualifiers are dropped
      v_d    = {DEPTH{1'b0}};
      fill_d = {CW{1'b0}};
    end else if (bus.en) begin
      // Bubbles still move data so the shift path is independent of d_valid
      s_d[0] = bus.d;
      v_d[0] = bus.d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        s_d[i] = s_q[i-1];
        v_d[i] = v_q[i-1];
      end
      // Count only moves when exactly one of entry/exit carries a valid word,
      // which keeps it inside 0..DEPTH by construction
      case ({bus.d_valid, v_q[DEPTH-1]})
        2'b10:   fill_d = fill_q + FILL_ONE;
        2'b01:   fill_d = fill_q - FILL_ONE;
        default: fill_d = fill_q;
      endcase
    end else begin
      // Stall: every register keeps its value
      v_d    = v_q;
      fill_d = fill_q;
    end
  end

  // State registers; reset clears in-flight data without waiting for an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= {WIDTH{1'b0}};
      end
      v_q    <= {DEPTH{1'b0}};
      fill_q <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i] <= s_d[i];
      end
      v_q    <= v_d;
      fill_q <= fill_d;
    end
  end

  assign bus.q          = s_q[DEPTH-1];
  assign bus.q_valid    = v_q[DEPTH-1];
  assign bus.fill_count = fill_q;

endmodule

// File: tb/tb_d_ff_pipe.sv
// Scoreboard bench for d_ff_pipe: a directed driver pushes hand-computed
// per-edge expectations into queues, independent monitors pop and compare.
module tb_d_ff_pipe;

  logic clk;
  logic reset;

  d_ff_pipe_if #(.WIDTH(8), .DEPTH(4)) bus8 ();
  d_ff_pipe_if #(.WIDTH(1), .DEPTH(1)) bus1 ();

  d_ff_pipe #(.WIDTH(8), .DEPTH(4), .PRESET_VAL(8'hA5)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  d_ff_pipe #(.WIDTH(1), .DEPTH(1), .PRESET_VAL(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct packed {
    logic [7:0] q;
    logic       qv;
    logic [2:0] fill;
  } exp8_t;

  typedef struct packed {
    logic q;
    logic qv;
    logic fill;
  } exp1_t;

  exp8_t exp8_q[$];
  exp1_t exp1_q[$];
  int    n_vec = 0;
  int    n_mis = 0;
  int    idx8  = 0;
  int    idx1  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string name, input exp8_t e);
    n_vec++;
    if ({bus8.q, bus8.q_valid, bus8.fill_count} !== {e.q, e.qv, e.fill}) begin
      n_mis++;
      $display("FAIL %s: got q=%02h q_valid=%0b fill=%0d, want q=%02h q_valid=%0b fill=%0d",
               name, bus8.q, bus8.q_valid, bus8.fill_count, e.q, e.qv, e.fill);
    end
  endtask

  task automatic check1(input string name, input exp1_t e);
    n_vec++;
    if ({bus1.q, bus1.q_valid, bus1.fill_count} !== {e.q, e.qv, e.fill}) begin
      n_mis++;
      $display("FAIL %s: got q=%0b q_valid=%0b fill=%0d, want q=%0b q_valid=%0b fill=%0d",
               name, bus1.q, bus1.q_valid, bus1.fill_count, e.q, e.qv, e.fill);
    end
  endtask

  // Monitors: one expectation per active edge, compared just after the edge
  initial begin
    exp8_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp8_q.size() > 0) begin
        e = exp8_q.pop_front();
        check8($sformatf("w8_vec%0d", idx8), e);
        idx8++;
      end
    end
  end

  initial begin
    exp1_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp1_q.size() > 0) begin
        e = exp1_q.pop_front();
        check1($sformatf("w1_vec%0d", idx1), e);
        idx1++;
      end
    end
  end

  // Drive one edge on the 8-bit pipeline and queue its expected outputs
  task automatic step8(input logic rst, input logic pre, input logic fl, input logic e,
                       input logic [7:0] din, input logic dv,
                       input logic [7:0] xq, input logic xqv, input logic [2:0] xf);
    exp8_t x;
    @(negedge clk);
    reset        = rst;
    bus8.preset  = pre;
    bus8.flush   = fl;
    bus8.en      = e;
    bus8.d       = din;
    bus8.d_valid = dv;
    x.q = xq; x.qv = xqv; x.fill = xf;
    exp8_q.push_back(x);
  endtask

  // Drive one edge on the 1-bit, single-stage pipeline
  task automatic step1(input logic rst, input logic pre, input logic e,
                       input logic din, input logic dv,
                       input logic xq, input logic xqv, input logic xf);
    exp1_t x;
    @(negedge clk);
    reset        = rst;
    bus1.preset  = pre;
    bus1.flush   = 1'b0;
    bus1.en      = e;
    bus1.d       = din;
    bus1.d_valid = dv;
    x.q = xq; x.qv = xqv; x.fill = xf;
    exp1_q.push_back(x);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp8_t z;
    reset        = 1'b0;
    bus8.preset  = 1'b0; bus8.flush = 1'b0; bus8.en = 1'b0;
    bus8.d       = 8'h00; bus8.d_valid = 1'b0;
    bus1.preset  = 1'b0; bus1.flush = 1'b0; bus1.en = 1'b0;
    bus1.d       = 1'b0; bus1.d_valid = 1'b0;

    // Reset held for two edges
    step8(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
    step8(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
    // Stream 01..05
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 3'd1);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 8'h00, 1'b0, 3'd2);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 8'h00, 1'b0, 3'd3);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 8'h01, 1'b1, 3'd4);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 8'h02, 1'b1, 3'd4);
    // Stall with FF on the input
    step8(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd4);
    step8(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd4);
    step8(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd4);
    // Resume, then drain with bubbles
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h06, 1'b1, 8'h03, 1'b1, 3'd4);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h04, 1'b1, 3'd3);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h05, 1'b1, 3'd2);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h06, 1'b1, 3'd1);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
    // Bubble pattern 1,0,1,0
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 8'h00, 1'b0, 3'd1);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 8'h00, 1'b0, 3'd1);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h30, 1'b1, 8'h00, 1'b0, 3'd2);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h10, 1'b1, 3'd2);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h20, 1'b0, 3'd1);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h30, 1'b1, 3'd1);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h40, 1'b0, 3'd0);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
    // Preset and flush together, then flush alone, then flush while stalled
    step8(1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'hA5, 1'b1, 3'd4);
    step8(1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 8'hA5, 1'b0, 3'd0);
    step8(1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 8'hA5, 1'b0, 3'd0);
    // Build occupancy 3
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 8'hA5, 1'b0, 3'd1);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 8'hA5, 1'b0, 3'd2);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h23, 1'b1, 8'hA5, 1'b0, 3'd3);
    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    z.q = 8'h00; z.qv = 1'b0; z.fill = 3'd0;
    check8("async_reset", z);
    step8(1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 8'h00, 1'b0, 3'd0);
    // Fresh stream after release
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 3'd1);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 8'h00, 1'b0, 3'd2);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 8'h00, 1'b0, 3'd3);
    step8(1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 8'h01, 1'b1, 3'd4);
    step8(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 3'd4);

    // Single-bit, single-stage regression (8-bit pipeline idle)
    step1(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Let the monitors drain, bounded
    for (int i = 0; i < 20 && (exp8_q.size() > 0 || exp1_q.size() > 0); i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    if (exp8_q.size() > 0 || exp1_q.size() > 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain: %0d/%0d expectations left, want 0",
               exp8_q.size(), exp1_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/d_ff_pipe.md
Name: d_ff_pipe

Overview:
Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage D-register pipeline with per-stage valid tracking, stall, synchronous preset and flush. It is used wherever the design needs a multi-cycle, stallable delay line for a data bus, and it reports its occupancy. It sits in the same layered-testbench environment: one interface, a driver on d/d_valid/en, and a monitor on q/q_valid/fill_count.

Parameters:
WIDTH, 8, data bus width in bits (>=1)
DEPTH, 4, number of register stages (>=1); latency in enabled cycles
PRESET_VAL, {WIDTH{1'b1}}, value loaded into every stage by preset

Ports:
clk  input  1  single clock, rising-edge
reset  input  1  asynchronous, active-low reset
preset  input  1  synchronous, active-high; loads PRESET_VAL into all stages
flush  input  1  synchronous, active-high; clears all valid bits, data retained
en  input  1  advance enable; 0 = stall (hold all state)
d  input  WIDTH  input data
d_valid  input  1  qualifies d
q  output  WIDTH  data of last stage
q_valid  output  1  valid bit of last stage
fill_count  output  $clog2(DEPTH+1)  number of stages currently holding valid data

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (ports named clk and reset).
- State: stage data s[0..DEPTH-1] (WIDTH bits each), stage valid v[0..DEPTH-1], and a fill_count register. s[0] is the input stage; q = s[DEPTH-1]; q_valid = v[DEPTH-1]. All outputs are driven directly from registers, with no combinational path from inputs to outputs.
- Reset (reset=0, asynchronous, independent of clk): all s = 0, all v = 0, fill_count = 0, so q = 0 and q_valid = 0. Reset release is synchronised by the clock edge only; the first edge with reset=1 applies normal rules.
- Priority per rising edge when reset=1: preset > flush > en > hold.
- Preset: every s = PRESET_VAL, every v = 1, fill_count = DEPTH. en, flush and d are ignored that cycle.
- Flush (preset=0): every v = 0 and fill_count = 0. Data registers keep their values, so q holds its last value with q_valid = 0.
- Advance (preset=0, flush=0, en=1):
  - s[0] <= d and v[0] <= d_valid.
  - s[i] <= s[i-1] and v[i] <= v[i-1] for i = 1..DEPTH-1.
  - Data is captured even when d_valid=0 (bubble carries stale data, valid=0).
- Stall (en=0, no preset or flush): all state holds, including q, q_valid and fill_count.
- fill_count on advance: next = fill_count + d_valid - v[DEPTH-1]. It never exceeds DEPTH and never underflows. At full occupancy with d_valid=1, the count stays at DEPTH. When empty with d_valid=0, it stays at 0.
- Latency: d sampled at enabled edge k appears on q after enabled edge k+DEPTH-1, i.e. DEPTH enabled edges total. Stalled cycles add no latency beyond their count.
- DEPTH=1 reduces to a single WIDTH-bit register with valid, preset and enable. This must be behaviourally equivalent to the original d_ff when WIDTH=1, en=1 and d_valid=1.
- Reset asserted mid-stream discards all in-flight data immediately, without waiting for a clock edge.
- X on d when d_valid=0 must not propagate to q_valid or fill_count.

Test Plan:
- Reset then stream (WIDTH=8, DEPTH=4): reset low for 2 cycles, then en=1 and d=8'h01,02,03,04,05 all valid → q=0 and q_valid=0 until 4th enabled edge; then q=8'h01 with q_valid=1, followed by 8'h02 on the next edge; fill_count goes 1,2,3,4,4.
- Stall: at fill_count=4, drop en for 3 cycles with d=8'hFF → q, q_valid and fill_count frozen; on resuming, the output sequence continues exactly where it stopped and 8'hFF is never captured.
- Bubbles: d_valid pattern 1,0,1,0 with d=8'h10,8'h20,8'h30,8'h40 → q_valid pattern 1,0,1,0 delayed by 4 edges; valid data 8'h10 and 8'h30; fill_count never exceeds 2.
- Preset vs flush priority (PRESET_VAL=8'hA5): assert preset and flush together for one edge → all stages 8'hA5, q_valid=1, fill_count=4. Next edge flush alone → q stays 8'hA5, q_valid=0, fill_count=0.
- Async reset mid-operation: with fill_count=3, pull reset low between clock edges → q=0, q_valid=0 and fill_count=0 immediately, before the next edge; after release, a fresh stream of 4 words behaves exactly as in the first scenario.
- DEPTH=1, WIDTH=1 regression: replay the original d_ff sequence (reset, then preset, then toggling d) → q follows d after one edge; preset forces q=1.
